hsv_axi_mem_responder: RTL
==========================

Name: hsv_axi_mem_responder

Overview:
- AXI4 subordinate (responder) backed by a local word-addressed SRAM array.
- Serves as the far end of the core's memory-unit AXI initiator: boot ROM/RAM model in simulation, on-chip scratchpad in FPGA builds.
- Independent read and write channel FSMs; one outstanding burst per direction; FIXED, INCR and WRAP bursts.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of two.
- BASE, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1/1  write address handshake
- awaddr  in  32  write start byte address
- awlen  in  8  beats-1
- awsize  in  3  axi_size_t
- awburst  in  2  axi_burst_t
- wvalid/wready  in/out  1/1  write data handshake
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wlast  in  1  last write beat
- bvalid/bready  out/in  1/1  write response handshake
- bresp  out  2  axi_resp_t
- arvalid/arready  in/out  1/1  read address handshake
- araddr  in  32  read start byte address
- arlen  in  8  beats-1
- arsize  in  3  axi_size_t
- arburst  in  2  axi_burst_t
- rvalid/rready  out/in  1/1  read data handshake
- rdata  out  32  read data
- rresp  out  2  axi_resp_t
- rlast  out  1  last read beat

Behaviour:
- Reset (async assert, sync deassert): write FSM W_IDLE, read FSM R_IDLE; awready=arready=1; wready=bvalid=rvalid=rlast=0; bresp=rresp=OKAY; rdata=0. Memory contents are not reset. Reset mid-burst abandons the burst silently; no B or R is produced.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch addr/len/size/burst, clear beat counter and error flag, go W_DATA.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes to word (addr-BASE)>>2 and advances the address.
  - Burst ends after exactly awlen+1 beats, then go W_RESP.
  - wlast high on a non-final beat, or low on the final beat, sets the error flag. The burst length is still governed by awlen.
  - W_RESP: bvalid=1 and held until bready; bresp is SLVERR if the error flag is set, else OKAY. Then go W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch fields, issue a synchronous SRAM read of the start word, go R_DATA. rvalid rises the next cycle (1-cycle latency).
  - R_DATA: hold rvalid/rdata/rresp/rlast stable until rready. On handshake, the SRAM reads the next beat address that same cycle, so bursts run back-to-back with no bubble.
  - rlast is high on beat arlen. After its handshake, go R_IDLE.
- Address generation:
  - FIXED: address constant.
  - INCR: next = (addr aligned down to 1<<size) + (1<<size).
  - WRAP: wrap boundary = (len+1)<<size; low bits wrap inside the boundary-aligned window.
  - Arithmetic is 32-bit unsigned, wraps modulo 2^32.
- Error per beat (SLVERR):
  - address outside [BASE, BASE+DEPTH*4);
  - size > AXI_SIZE_4;
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned start address.
  - Erroring write beats do not modify memory. Erroring read beats return rdata=0, rresp=SLVERR.
  - An error on any write beat makes the whole B response SLVERR. Read errors are reported per beat.
- Narrow transfers: rdata is always the full word; the write lane is selected only by wstrb.
- Read/write collision: a same-cycle read and write to the same word returns the old data (read-before-write).
- Read and write channels operate concurrently with no ordering between them.
- EXOKAY is never returned.

Optional Feature:
HSV_AXI_RESP_STALL_EN
- With the macro: a 16-bit LFSR (seed 16'hACE1, advances every cycle) gates awready, wready, arready and rvalid. Each is forced low when its assigned LFSR bit is 0, to exercise initiator backpressure handling.
- rvalid, once high, is never dropped before its handshake; the gate only delays its rise.
- Without the macro: no gating; timing as described above.

Decomposition:
- Add to hsv_core_pkg:
  - typedef logic [7:0] axi_len_t;
  - enum axi_wr_state_t {W_IDLE, W_DATA, W_RESP};
  - enum axi_rd_state_t {R_IDLE, R_DATA};
  - function axi_size_bytes(axi_size_t).
- One sub-module: hsv_axi_burst_addr, a combinational next-address and per-beat error-check unit, instantiated once per channel.

Test Plan:
- INCR write: AW addr 0x100, len 3, size 4; wdata 1..4, wstrb F; then INCR read of the same burst → B OKAY; R returns 1,2,3,4 with rlast only on beat 4 and no bubbles under rready=1.
- WRAP read: addr 0x18, len 3, size 4 → R addresses 0x18, 0x1C, 0x10, 0x14.
- Write to addr BASE+DEPTH*4 with len 0 → bresp SLVERR; a subsequent read of word 0 is unchanged. Read of the same address → rdata 0, rresp SLVERR.
- Write len 1 with wlast asserted on beat 0 → two beats consumed; bresp SLVERR.
- rready low for 5 cycles mid-burst → rvalid, rdata and rlast stable throughout; no beat lost or duplicated.
- Assert rst_core_n low during W_DATA → next cycle awready=1, bvalid=0; a new burst completes normally.

Source files
------------

// File: rtl/hsv_axi_mem_responder_pkg.sv
// Shared AXI4 types for the core memory path: burst/size/resp encodings,
// responder channel FSM states and the size-to-bytes helper.
package hsv_core_pkg;

  typedef enum logic [2:0] {
    AXI_SIZE_1   = 3'd0,
    AXI_SIZE_2   = 3'd1,
    AXI_SIZE_4   = 3'd2,
    AXI_SIZE_8   = 3'd3,
    AXI_SIZE_16  = 3'd4,
    AXI_SIZE_32  = 3'd5,
    AXI_SIZE_64  = 3'd6,
    AXI_SIZE_128 = 3'd7
  } axi_size_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2,
    AXI_BURST_RSVD  = 2'd3
  } axi_burst_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_resp_t;

  typedef logic [7:0] axi_len_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} axi_wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         axi_rd_state_t;

  function automatic logic [31:0] axi_size_bytes(axi_size_t size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/hsv_axi_mem_responder_burst_addr.sv
// Combinational AXI beat address stepper plus per-beat legality check
// (range, size, WRAP length/alignment). One instance per channel.
module hsv_axi_burst_addr
  import hsv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_o,
  output logic        err_o
);

  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  logic [31:0] bytes, aligned, incr, wrap_msk, offs;
  logic        wrap_len_ok, is_wrap;

  always_comb begin
    bytes       = axi_size_bytes(axi_size_t'(size_i));
    aligned     = addr_i & ~(bytes - 32'd1);
    incr        = aligned + bytes;
    wrap_msk    = (({24'd0, len_i} + 32'd1) << size_i) - 32'd1;
    offs        = addr_i - BASE;
    is_wrap     = burst_i == 2'(AXI_BURST_WRAP);
    wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    case (axi_burst_t'(burst_i))
      AXI_BURST_FIXED: next_o = addr_i;
      // Only the low bits inside the (len+1)<<size window roll over.
      AXI_BURST_WRAP:  next_o = (addr_i & ~wrap_msk) | (incr & wrap_msk);
      default:         next_o = incr;
    endcase
    err_o = (offs >= SPAN) || (size_i > 3'(AXI_SIZE_4)) ||
            (is_wrap && (!wrap_len_ok || aligned != addr_i));
  end

endmodule

// File: rtl/hsv_axi_mem_responder.sv
// AXI4 responder over a word-addressed SRAM, independent read/write FSMs.
// Define HSV_AXI_RESP_STALL_EN to add LFSR-driven backpressure on AW/W/AR/R.
module hsv_axi_mem_responder
  import hsv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];

  logic aw_gate, w_gate, ar_gate, r_gate;
`ifdef HSV_AXI_RESP_STALL_EN
  logic [15:0] lfsr_q;
  logic        rv_held_q;
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      lfsr_q    <= 16'hACE1;
      rv_held_q <= 1'b0;
    end else begin
      lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      rv_held_q <= rvalid & ~rready;
    end
  end
  assign aw_gate = lfsr_q[0];
  assign w_gate  = lfsr_q[1];
  assign ar_gate = lfsr_q[2];
  // Once rvalid is shown it stays up until accepted.
  assign r_gate  = lfsr_q[3] | rv_held_q;
`else
  assign aw_gate = 1'b1;
  assign w_gate  = 1'b1;
  assign ar_gate = 1'b1;
  assign r_gate  = 1'b1;
`endif

  // ---------------- write channel ----------------
  axi_wr_state_t wst_q, wst_d;
  logic [31:0] waddr_q, waddr_d, wnext;
  logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic        werr_q, werr_d, wbeat_err, w_hs, wfinal, mem_we;
  logic [AW-1:0] widx;

  hsv_axi_burst_addr #(.DEPTH(DEPTH), .BASE(BASE)) u_waddr (
    .addr_i(waddr_q), .len_i(wlen_q), .size_i(wsize_q), .burst_i(wburst_q),
    .next_o(wnext), .err_o(wbeat_err)
  );

  assign awready = (wst_q == W_IDLE) & aw_gate;
  assign wready  = (wst_q == W_DATA) & w_gate;
  assign bvalid  = (wst_q == W_RESP);
  assign bresp   = werr_q ? 2'(AXI_RESP_SLVERR) : 2'(AXI_RESP_OKAY);
  assign w_hs    = wvalid & wready;
  assign wfinal  = (wcnt_q == wlen_q);
  assign mem_we  = w_hs & ~wbeat_err;
  assign widx    = AW'((waddr_q - BASE) >> 2);

  always_comb begin
    wst_d    = wst_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    case (wst_q)
      W_IDLE: if (awvalid & awready) begin
        waddr_d  = awaddr;
        wlen_d   = awlen;
        wsize_d  = awsize;
        wburst_d = awburst;
        wcnt_d   = '0;
        werr_d   = 1'b0;
        wst_d    = W_DATA;
      end
      // awlen alone sets the beat count; a misplaced wlast only flags an error.
      W_DATA: if (w_hs) begin
        werr_d  = werr_q | wbeat_err | (wlast != wfinal);
        waddr_d = wnext;
        wcnt_d  = wcnt_q + 8'd1;
        if (wfinal) wst_d = W_RESP;
      end
      W_RESP: if (bready) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wst_q    <= W_IDLE;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
    end else begin
      wst_q    <= wst_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wsize_q  <= wsize_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
    end
  end

  always_ff @(posedge clk_core) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
  end

  // ---------------- read channel ----------------
  // raddr_q holds the address of the next beat to fetch, not the one on R.
  axi_rd_state_t rdst_q, rdst_d;
  logic [31:0] raddr_q, raddr_d, rnext, ra_addr, rdata_q;
  logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d, ra_len;
  logic [2:0]  rsize_q, rsize_d, ra_size;
  logic [1:0]  rburst_q, rburst_d, ra_burst, rresp_q;
  logic        rvalid_q, rvalid_d, rlast_q, rlast_d, rbeat_err, ar_hs, r_hs, rd_issue;
  logic [AW-1:0] ridx;

  assign ra_addr  = (rdst_q == R_IDLE) ? araddr  : raddr_q;
  assign ra_len   = (rdst_q == R_IDLE) ? arlen   : rlen_q;
  assign ra_size  = (rdst_q == R_IDLE) ? arsize  : rsize_q;
  assign ra_burst = (rdst_q == R_IDLE) ? arburst : rburst_q;

  hsv_axi_burst_addr #(.DEPTH(DEPTH), .BASE(BASE)) u_raddr (
    .addr_i(ra_addr), .len_i(ra_len), .size_i(ra_size), .burst_i(ra_burst),
    .next_o(rnext), .err_o(rbeat_err)
  );

  assign arready  = (rdst_q == R_IDLE) & ar_gate;
  assign rvalid   = rvalid_q & r_gate;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign rlast    = rlast_q;
  assign ar_hs    = arvalid & arready;
  assign r_hs     = rvalid & rready;
  assign rd_issue = ar_hs | (r_hs & ~rlast_q);
  assign ridx     = AW'((ra_addr - BASE) >> 2);

  always_comb begin
    rdst_d   = rdst_q;
    raddr_d  = raddr_q;
    rlen_d   = rlen_q;
    rsize_d  = rsize_q;
    rburst_d = rburst_q;
    rcnt_d   = rcnt_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    case (rdst_q)
      R_IDLE: if (ar_hs) begin
        rlen_d   = arlen;
        rsize_d  = arsize;
        rburst_d = arburst;
        raddr_d  = rnext;
        rcnt_d   = '0;
        rvalid_d = 1'b1;
        rlast_d  = (arlen == 8'd0);
        rdst_d   = R_DATA;
      end
      R_DATA: if (r_hs) begin
        if (rlast_q) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          rdst_d   = R_IDLE;
        end else begin
          raddr_d = rnext;
          rcnt_d  = rcnt_q + 8'd1;
          rlast_d = (rcnt_q + 8'd1 == rlen_q);
        end
      end
      default: rdst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rdst_q   <= R_IDLE;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rcnt_q   <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      rdst_q   <= rdst_d;
      raddr_q  <= raddr_d;
      rlen_q   <= rlen_d;
      rsize_q  <= rsize_d;
      rburst_q <= rburst_d;
      rcnt_q   <= rcnt_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
    end
  end

  // Same-edge write is a non-blocking update, so a colliding read sees old data.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rdata_q <= '0;
      rresp_q <= 2'(AXI_RESP_OKAY);
    end else if (rd_issue) begin
      rdata_q <= rbeat_err ? 32'd0 : mem_q[ridx];
      rresp_q <= rbeat_err ? 2'(AXI_RESP_SLVERR) : 2'(AXI_RESP_OKAY);
    end
  end

endmodule
